tl_mem_responder: RTL

TileLink-UH single-beat responder terminating the A channel produced by the upstream 117-bit request queue and generating the D channel back toward the requester. Requests hit a small flop-based scratchpad (clear-on-reset), with ordered responses drained through a 3-entry response FIFO. The block is the responder end of the same A/D link, used as a debug/boot scratchpad and as a bench target for the request path.

---
 rtl/tl_resp_pkg.sv | 44 ++++
 rtl/tl_resp_fifo.sv | 64 ++++++
 rtl/tl_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tl_resp_pkg.sv
// rtl/tl_resp_pkg.sv - TileLink A/D opcode constants, response payload type, FSM states
package tl_resp_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    localparam int RESP_DEPTH = 3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic        source;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } resp_t;

    function automatic logic a_opcode_legal(input logic [2:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) || (op == A_GET);
    endfunction

    // Low address bits must be zero up to the transfer size; sizes above
    // 3 are rejected separately, so they never report misalignment here.
    function automatic logic a_misaligned(input logic [2:0] addr_lo, input logic [3:0] size);
        logic mis;
        case (size)
            4'd1:    mis = addr_lo[0];
            4'd2:    mis = |addr_lo[1:0];
            4'd3:    mis = |addr_lo[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// rtl/tl_resp_fifo.sv - three-entry ordered response queue with flop storage
module tl_resp_fifo
    import tl_resp_pkg::*;
(
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       push_i,
    input  resp_t      push_data_i,
    input  logic       pop_i,
    output resp_t      head_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    resp_t      entries_q [RESP_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RESP_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Pointer and occupancy bookkeeping; a push into a full queue is only
    // taken when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'(RESP_DEPTH)) || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are only observed while the queue is non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = entries_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/tl_mem_responder.sv
// rtl/tl_mem_responder.sv - TileLink-UH single-beat scratchpad responder
module tl_mem_responder
    import tl_resp_pkg::*;
#(
    parameter int          DEPTH = 16,
    parameter logic [32:0] BASE  = 33'h0_0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_a_ready,
    input  logic        io_a_valid,
    input  logic [2:0]  io_a_bits_opcode,
    input  logic [3:0]  io_a_bits_size,
    input  logic        io_a_bits_source,
    input  logic [32:0] io_a_bits_address,
    input  logic [7:0]  io_a_bits_mask,
    input  logic [63:0] io_a_bits_data,
    input  logic        io_d_ready,
    output logic        io_d_valid,
    output logic [2:0]  io_d_bits_opcode,
    output logic [2:0]  io_d_bits_param,
    output logic [3:0]  io_d_bits_size,
    output logic        io_d_bits_source,
    output logic        io_d_bits_denied,
    output logic [63:0] io_d_bits_data,
    output logic        io_d_bits_corrupt
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH * 8);

    state_t         state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic           init_we;
    logic           a_ready;
    logic           a_fire;
    logic [2:0]     occupancy;

    logic           s1_valid_q;
    logic [2:0]     s1_opcode_q;
    logic [3:0]     s1_size_q;
    logic           s1_source_q;
    logic [32:0]    s1_addr_q;
    logic [7:0]     s1_mask_q;
    logic [63:0]    s1_data_q;

    logic [63:0]    mem_q [DEPTH];

    logic [32:0]    offset;
    logic [AW-1:0]  word_idx;
    logic           denied;
    logic           is_get;
    logic           is_put;
    logic           put_we;
    resp_t          resp;

    resp_t          fifo_head;
    logic           fifo_valid;
    logic [1:0]     fifo_count;
    logic           fifo_pop;

    // Requests in stage 1 count against the queue so its push never overflows.
    assign occupancy = {1'b0, fifo_count} + {2'b00, s1_valid_q};

    // FSM state and INIT word pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: INIT sweeps every word to zero, RUN accepts requests.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        init_we = 1'b0;
        a_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                ptr_d   = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end
            end
            ST_RUN: begin
                a_ready = (occupancy < 3'(RESP_DEPTH));
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    assign a_fire     = io_a_valid && a_ready;
    assign io_a_ready = a_ready;

    // Stage-1 occupancy flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= a_fire;
        end
    end

    // Stage-1 request capture; fields are ignored while s1_valid_q is low.
    always_ff @(posedge clock) begin
        if (a_fire) begin
            s1_opcode_q <= io_a_bits_opcode;
            s1_size_q   <= io_a_bits_size;
            s1_source_q <= io_a_bits_source;
            s1_addr_q   <= io_a_bits_address;
            s1_mask_q   <= io_a_bits_mask;
            s1_data_q   <= io_a_bits_data;
        end
    end

    // Decode the stage-1 request and build its response.
    always_comb begin
        offset   = s1_addr_q - BASE;
        word_idx = offset[AW+2:3];
        denied   = (offset >= SPAN) || (s1_size_q > 4'd3) ||
                   a_misaligned(s1_addr_q[2:0], s1_size_q) || !a_opcode_legal(s1_opcode_q);
        is_get   = (s1_opcode_q == A_GET);
        is_put   = (s1_opcode_q == A_PUT_FULL) || (s1_opcode_q == A_PUT_PARTIAL);
        put_we   = s1_valid_q && is_put && !denied;

        resp        = '0;
        resp.size   = s1_size_q;
        resp.source = s1_source_q;
        resp.denied = denied;
        resp.opcode = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
        if (denied) begin
            resp.corrupt = is_get;
        end else if (is_get) begin
            resp.data = mem_q[word_idx];
        end
    end

    // Scratchpad: zero sweep during INIT, byte-masked Put writes during RUN.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem_q[ptr_q] <= '0;
        end else if (put_we) begin
            for (int b = 0; b < 8; b++) begin
                if (s1_mask_q[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= s1_data_q[b*8 +: 8];
                end
            end
        end
    end

    assign fifo_pop = fifo_valid && io_d_ready;

    tl_resp_fifo u_resp_fifo (
        .clk_i       (clock),
        .resetn_i    (reset),
        .push_i      (s1_valid_q),
        .push_data_i (resp),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign io_d_valid        = fifo_valid;
    assign io_d_bits_opcode  = fifo_valid ? fifo_head.opcode  : 3'd0;
    assign io_d_bits_param   = 3'd0;
    assign io_d_bits_size    = fifo_valid ? fifo_head.size    : 4'd0;
    assign io_d_bits_source  = fifo_valid ? fifo_head.source  : 1'b0;
    assign io_d_bits_denied  = fifo_valid ? fifo_head.denied  : 1'b0;
    assign io_d_bits_data    = fifo_valid ? fifo_head.data    : 64'd0;
    assign io_d_bits_corrupt = fifo_valid ? fifo_head.corrupt : 1'b0;

endmodule
